mips_muldiv_unit: RTL
=====================

Name: mips_muldiv_unit

Overview:
Parametrised iterative multiply/divide unit with architectural HI/LO registers. It extends the pipelined MIPS core with MULT/MULTU/DIV/DIVU, MFHI/MFLO and MTHI/MTLO support. It sits beside the EX stage and takes operands after forwarding. It reports busy/stall to the hazard detection logic, and accepts a flush from the control-hazard nullify path.

Parameters:
WIDTH, 32, operand and HI/LO width in bits (even, >=4)
CNT_W, $clog2(WIDTH)+1, iteration counter width

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  launch operation (EX stage holds a mult/div instr)
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
srca  input  WIDTH  rs operand (multiplicand / dividend), post-forwarding
srcb  input  WIDTH  rt operand (multiplier / divisor), post-forwarding
flush  input  1  abort in-flight operation (pipeline nullify)
mthi  input  1  write HI from wdata
mtlo  input  1  write LO from wdata
wdata  input  WIDTH  data for mthi/mtlo
rd_hilo  input  1  ID stage holds mfhi/mflo/mthi/mtlo/mult/div
busy  output  1  operation in progress
done  output  1  one-cycle pulse: HI/LO just updated by an operation
stall  output  1  busy & rd_hilo (combinational), to the hazard unit
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (async): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal accumulators=0.
- States: IDLE, MUL, DIV, FIXUP.
- IDLE:
  - start=1 and flush=0 at edge E0: latch magnitudes of srca/srcb (two's-complement abs for signed ops; raw for unsigned), latch the result-sign flags, counter=0, busy=1.
  - Next state is MUL or DIV by op[1].
- MUL: radix-2 shift-add, one multiplier bit per edge. After WIDTH steps go to FIXUP.
- DIV: restoring division, one quotient bit per edge. After WIDTH steps go to FIXUP.
- FIXUP, one cycle:
  - Negate the product if the MULT signs differ.
  - Negate the quotient if the DIV signs differ.
  - The remainder takes the dividend's sign.
  - At edge E(WIDTH+1): MUL writes hi=product[2W-1:W], lo=product[W-1:0]; DIV writes hi=remainder, lo=quotient.
  - At the same edge: done=1 for the following cycle only, busy=0, state=IDLE.
- Latency: HI/LO update WIDTH+1 edges after the start edge (33 for WIDTH=32). The next start is accepted in the cycle done is high.
- busy is high from E0 until the HI/LO write edge.
- Divide by zero: no exception.
  - DIVU: hi=srca, lo=all ones.
  - DIV: apply the FIXUP sign rules to those magnitudes.
- DIV of MIN by -1: lo=MIN, hi=0. This wraps with no error.
- start while busy: ignored. The hazard unit must stall using the stall output.
- mthi/mtlo:
  - Take effect at the next edge only in IDLE, and only with no start that cycle. start wins, and the write is dropped.
  - mthi and mtlo together: both written with wdata.
  - While busy: ignored.
- flush (synchronous):
  - In MUL/DIV/FIXUP: go to IDLE next edge; hi/lo unchanged; no done; busy=0.
  - In IDLE: suppresses start, mthi and mtlo that cycle.
- reset mid-operation: immediate return to the reset values. No partial HI/LO write.

Optional Feature:
MIPS_MULDIV_EARLY_OUT_EN:
- Defined: MUL checks the remaining (shifted) multiplier magnitude at accept and after each step. When it is zero, the unit goes straight to FIXUP and the product is left-aligned correctly. Latency becomes (index of the highest set multiplier bit)+2 edges; a zero multiplier takes 1 edge to FIXUP, so the write lands on E2. DIV is unaffected.
- Undefined: MUL always takes WIDTH steps.

Test Plan:
- MULTU srca=0xFFFFFFFF, srcb=0xFFFFFFFF -> after 33 edges hi=0xFFFFFFFE, lo=0x00000001, single done pulse, busy high for 33 cycles.
- MULT srca=-3 (0xFFFFFFFD), srcb=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. With MIPS_MULDIV_EARLY_OUT_EN the HI/LO write lands on E4.
- DIV srca=-7, srcb=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU srca=7, srcb=0 -> hi=7, lo=0xFFFFFFFF.
- DIV srca=0x80000000, srcb=0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi wdata=0x1234 in IDLE -> hi=0x1234 next edge. Then start a MULTU and assert flush at cycle 10 -> hi stays 0x1234, lo unchanged, no done, busy=0 next cycle. A start held during busy is ignored.
- Assert reset asynchronously mid-DIV (cycle 15) -> busy, done, hi and lo drop to 0 immediately. rd_hilo=1 while busy gives stall=1; rd_hilo=1 in IDLE gives stall=0.

Source files
------------

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers (option: MIPS_MULDIV_EARLY_OUT_EN)
module mips_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_hilo,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIXUP} state_t;
    state_t             r_state;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mc;
    logic [WIDTH-1:0]   r_mp;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic               r_div;
    logic               r_neg_lo;
    logic               r_neg_hi;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic               w_last;
    logic [WIDTH-1:0]   w_mp_next;
    logic               w_mul_end;
    logic [2*WIDTH-1:0] w_prod_next;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;
    logic [WIDTH-1:0]   w_hi_res;
    logic [WIDTH-1:0]   w_lo_res;
    // operand magnitudes: signed ops take two's-complement abs, unsigned ops pass through
    assign w_sa    = ~op[0] & srca[WIDTH-1];
    assign w_sb    = ~op[0] & srcb[WIDTH-1];
    assign w_abs_a = w_sa ? -srca : srca;
    assign w_abs_b = w_sb ? -srcb : srcb;
    assign w_last    = r_cnt == CNT_W'(WIDTH - 1);
    assign w_mp_next = r_mp >> 1;
`ifdef MIPS_MULDIV_EARLY_OUT_EN
    // the shifted multiplicand keeps the product aligned, so stopping early is exact
    assign w_mul_end = w_last || (w_mp_next == '0);
`else
    assign w_mul_end = w_last;
`endif
    // shift-add: product accumulates a left-shifting multiplicand per multiplier bit
    assign w_prod_next = r_acc + (r_mp[0] ? r_mc : '0);
    // restoring divide: r_acc holds {remainder, dividend/quotient}; trial subtract on the shifted remainder
    assign w_trial    = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_mc[WIDTH-1:0]};
    assign w_div_next = w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                       : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    // sign fix-up: product/quotient negate on differing signs, remainder follows the dividend
    assign w_prod_fix = r_neg_lo ? -r_acc : r_acc;
    assign w_q_fix    = r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_r_fix    = r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_hi_res   = r_div ? w_r_fix : w_prod_fix[2*WIDTH-1:WIDTH];
    assign w_lo_res   = r_div ? w_q_fix : w_prod_fix[WIDTH-1:0];
    // control FSM, iteration datapath and architectural HI/LO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_mc     <= '0;
            r_mp     <= '0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_div    <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (flush) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_div    <= op[1];
                            r_neg_lo <= w_sa ^ w_sb;
                            r_neg_hi <= w_sa;
                            r_cnt    <= '0;
                            r_busy   <= 1'b1;
                            r_acc    <= op[1] ? {{WIDTH{1'b0}}, w_abs_a} : '0;
                            r_mc     <= {{WIDTH{1'b0}}, op[1] ? w_abs_b : w_abs_a};
                            r_mp     <= w_abs_b;
                            r_state  <= op[1] ? DIV : MUL;
                        end else begin
                            if (mthi) r_hi <= wdata;
                            if (mtlo) r_lo <= wdata;
                        end
                    end
                    MUL: begin
                        r_acc <= w_prod_next;
                        r_mc  <= r_mc << 1;
                        r_mp  <= w_mp_next;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_mul_end) r_state <= FIXUP;
                    end
                    DIV: begin
                        r_acc <= w_div_next;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) r_state <= FIXUP;
                    end
                    FIXUP: begin
                        r_hi    <= w_hi_res;
                        r_lo    <= w_lo_res;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
    assign busy  = r_busy;
    assign done  = r_done;
    assign stall = r_busy & rd_hilo;
    assign hi    = r_hi;
    assign lo    = r_lo;
endmodule
